// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small circular-buffer FIFO that captures op-tagged ALU
// results under a valid/ready handshake and flags drops caused by a full
// buffer with a sticky bit that only clr or reset can lower.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_op,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH+1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             drop_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH+1:0] head;

  // Occupancy flags and handshake qualifiers; in_ready never looks at out_ready
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = ena & in_valid & ~full;
    pop   = ena & out_ready & ~empty;
  end

  // Pointer, occupancy and sticky-drop register; ena low freezes everything, clr wins over traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        drop_q  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        if (in_valid && full) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  // Storage write; contents are never reset since occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= {in_op, in_data};
    end
  end

  // Output view of the head entry, forced to zero when the buffer is empty
  always_comb begin
    head      = mem[rd_ptr];
    in_ready  = ena & ~full;
    out_valid = ena & ~empty;
    out_data  = '0;
    out_op    = '0;
    if (!empty) begin
      out_data = head[WIDTH-1:0];
      out_op   = head[WIDTH+1:WIDTH];
    end
    count = count_q;
    drop  = drop_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the FIFO.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             clr;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             drop;

  int checks;
  int errors;

  logic [WIDTH+1:0] model_q [$];
  logic             model_drop;

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_data(in_data), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_op(out_op), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .drop(drop)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all DUT outputs against what the reference queue implies
  task automatic checkAgainstModel(input string tag);
    logic [WIDTH+1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    checkOutput({tag, "_in_ready"},  16'(in_ready),  16'(ena && model_q.size() < DEPTH));
    checkOutput({tag, "_out_valid"}, 16'(out_valid), 16'(ena && model_q.size() > 0));
    checkOutput({tag, "_out_data"},  16'(out_data),  16'(head[WIDTH-1:0]));
    checkOutput({tag, "_out_op"},    16'(out_op),    16'(head[WIDTH+1:WIDTH]));
    checkOutput({tag, "_count"},     16'(count),     16'(model_q.size()));
    checkOutput({tag, "_drop"},      16'(drop),      16'(model_drop));
  endtask

  // One cycle: drive at the falling edge, check settled outputs, advance model, wait the rising edge
  task automatic applyStimulus(input logic e, input logic c, input logic iv,
                               input logic [WIDTH-1:0] d, input logic [1:0] op,
                               input logic ordy, input string tag);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    ena = e; clr = c; in_valid = iv; in_data = d; in_op = op; out_ready = ordy;
    #1;
    checkAgainstModel(tag);
    if (e) begin
      if (c) begin
        model_q.delete();
        model_drop = 1'b0;
      end else begin
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (iv && was_full) model_drop = 1'b1;
        if (ordy && !was_empty) void'(model_q.pop_front());
        if (iv && !was_full) model_q.push_back({op, d});
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] drain_exp [6];
    checks = 0;
    errors = 0;
    model_drop = 1'b0;
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_op = '0; out_ready = 1'b0;

    // Reset values while held in reset
    #2;
    checkAgainstModel("reset");
    checkOutput("reset_in_ready_const", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push after reset: invisible in the push cycle, visible next cycle
    applyStimulus(1, 0, 1, 8'h0C, 2'd0, 0, "push1");
    applyStimulus(1, 0, 0, 8'h00, 2'd0, 0, "push1_after");
    checkOutput("push1_data_const", 16'(out_data), 16'h0C);
    checkOutput("push1_count_const", 16'(count), 16'd1);

    // Fill and overflow
    applyStimulus(1, 1, 0, 8'h00, 2'd0, 0, "clr0");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1, 0, 1, 8'(i), 2'(i), 0, "fill");
    checkOutput("fill_count_const", 16'(count), 16'd4);
    checkOutput("fill_in_ready_const", 16'(in_ready), 16'd0);
    applyStimulus(1, 0, 1, 8'h05, 2'd1, 0, "overflow");
    checkOutput("overflow_drop_const", 16'(drop), 16'd1);
    checkOutput("overflow_head_const", 16'(out_data), 16'h01);

    // Drain with pointer wrap
    drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07};
    for (int i = 0; i < 2; i++) begin
      checkOutput("drain_order", 16'(out_data), 16'(drain_exp[i]));
      applyStimulus(1, 0, 0, 8'h00, 2'd0, 1, "drain_a");
    end
    applyStimulus(1, 0, 1, 8'h06, 2'd2, 0, "wrap_push6");
    applyStimulus(1, 0, 1, 8'h07, 2'd3, 0, "wrap_push7");
    for (int i = 2; i < 6; i++) begin
      checkOutput("drain_order", 16'(out_data), 16'(drain_exp[i]));
      applyStimulus(1, 0, 0, 8'h00, 2'd0, 1, "drain_b");
    end
    checkOutput("drain_empty_valid", 16'(out_valid), 16'd0);
    checkOutput("drain_empty_count", 16'(count), 16'd0);

    // Streaming with simultaneous push and pop
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 1, 8'(8'h20 + i), 2'(i), 1, "stream");
    checkOutput("stream_count_const", 16'(count), 16'd1);
    checkOutput("stream_tail_const", 16'(out_data), 16'h29);

    // Clear wins over push and pop with count 3 and drop set
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 1, 8'(8'h40 + i), 2'd0, 0, "cp_fill");
    applyStimulus(1, 0, 1, 8'h4F, 2'd0, 1, "cp_full_pushpop");
    checkOutput("cp_count3_const", 16'(count), 16'd3);
    checkOutput("cp_drop1_const", 16'(drop), 16'd1);
    applyStimulus(1, 1, 1, 8'h55, 2'd1, 1, "cp_clr");
    checkOutput("cp_count0_const", 16'(count), 16'd0);
    checkOutput("cp_drop0_const", 16'(drop), 16'd0);
    checkOutput("cp_valid0_const", 16'(out_valid), 16'd0);

    // Enable freeze with toggling controls
    applyStimulus(1, 0, 1, 8'hA1, 2'd2, 0, "fz_push");
    applyStimulus(1, 0, 1, 8'hA2, 2'd3, 0, "fz_push");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, i[0], ~i[0], 8'hEE, 2'd1, i[0], "freeze");
    applyStimulus(1, 0, 0, 8'h00, 2'd0, 0, "fz_after");
    checkOutput("fz_count_const", 16'(count), 16'd2);
    checkOutput("fz_head_const", 16'(out_data), 16'hA1);

    // Asynchronous reset between edges clears outputs immediately
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_drop = 1'b0;
    checkOutput("async_rst_count", 16'(count), 16'd0);
    checkOutput("async_rst_valid", 16'(out_valid), 16'd0);
    checkOutput("async_rst_data", 16'(out_data), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference queue
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 8) != 0, ($urandom % 25) == 0, $urandom % 2,
                    8'($urandom), 2'($urandom), ($urandom % 3) != 0, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
